// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU package: hazard-controller FSM state encoding and default data-memory wait limit.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam int WAIT_MAX_DEFAULT = 15;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds either ID source register.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_MemRead,
    output logic       load_use
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes, data-memory wait stalls with timeout.
// Define PIPE_HAZARD_PERF_EN to add the stall_cnt performance counter port.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_MemRead,
    input  logic        ex_branch_taken,
    input  logic        me_MemRead,
    input  logic        me_MemWrite,
    input  logic        dm_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        mem_req,
    output logic        mem_err
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    hz_state_e  state, state_nxt;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic       access;

    hazard_detect u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_rd      (ex_rd),
        .ex_MemRead (ex_MemRead),
        .load_use   (load_use)
    );

    assign access = me_MemRead | me_MemWrite;

    // Outputs are forced low while rst is high so a reset mid-wait releases the pipe at once.
    always_comb begin
        state_nxt    = state;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        mem_req      = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    mem_req = access;
                    if (access && !dm_ready) begin
                        // Whole pipe freezes; EX hazards are re-evaluated once memory releases.
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                        mem_wb_flush = 1'b1;
                        state_nxt    = MEM_WAIT;
                    end else if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    mem_req = 1'b1;
                    // mem_err high here marks the timeout cycle.
                    if (dm_ready || mem_err) begin
                        state_nxt = RUN;
                    end else begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                        mem_wb_flush = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // wait_cnt holds the number of completed MEM_WAIT cycles; mem_err is set one edge early
    // so the registered pulse lands on the WAIT_MAX-th wait cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RUN) begin
                wait_cnt <= 8'd0;
                mem_err  <= (state_nxt == MEM_WAIT) && (WAIT_MAX == 1);
            end else if (state_nxt == MEM_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
                mem_err  <= (wait_cnt == 8'(WAIT_MAX - 2));
            end else begin
                mem_err  <= 1'b0;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= 32'd0;
        else if (pc_stall)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, max data-memory wait cycles before timeout (1..255).
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset. Asynchronous, active-high.
- id_rs1, id_rs2  in  5 each  ID-stage source registers
- ex_rd  in  5  EX-stage destination
- ex_MemRead  in  1  EX-stage instruction is a load
- ex_branch_taken  in  1  EX-stage branch/jump resolved taken
- me_MemRead, me_MemWrite  in  1 each  MEM-stage access
- dm_ready  in  1  data memory completes access
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold register
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load bubble
- mem_req  out  1  access request to data memory
- mem_err  out  1  one-cycle timeout pulse
- stall_cnt  out  32  stall-cycle count (only with macro)

Function
REQ-003 SHALL implement FSM states RUN and MEM_WAIT.
REQ-004 RUN, load-use: ex_MemRead && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2) SHALL assert pc_stall, if_id_stall, id_ex_flush combinationally, same cycle; exactly one bubble.
REQ-005 RUN, ex_branch_taken SHALL assert if_id_flush and id_ex_flush same cycle, and deassert pc_stall/if_id_stall (branch beats load-use).
REQ-006 RUN, me_MemRead|me_MemWrite SHALL assert mem_req combinationally; if dm_ready same cycle, stay RUN with no stall (zero-wait).
REQ-007 RUN with access and !dm_ready SHALL move to MEM_WAIT next edge and assert all four stalls plus mem_wb_flush in that cycle.
REQ-008 MEM_WAIT SHALL hold mem_req=1, all four stalls=1, mem_wb_flush=1; SHALL suppress if_id_flush, id_ex_flush, load-use actions (EX held, re-evaluated after release).
REQ-009 MEM_WAIT with dm_ready SHALL deassert stalls and mem_wb_flush that cycle and return to RUN next edge.
REQ-010 8-bit wait counter SHALL clear on entering MEM_WAIT, increment each MEM_WAIT cycle without dm_ready; at WAIT_MAX SHALL pulse mem_err one cycle, release stalls that cycle, return to RUN.
REQ-011 dm_ready outside any access SHALL be ignored.
REQ-012 Back-to-back accesses SHALL each pass through REQ-006/007 independently; no idle cycle inserted.
REQ-013 Outputs other than mem_err and stall_cnt SHALL be combinational from state and inputs; mem_err registered.

Reset
REQ-014 rst SHALL force state RUN, wait counter 0, mem_err 0, stall_cnt 0 asynchronously; mid-MEM_WAIT reset SHALL drop mem_req and all stalls immediately.

Configuration
REQ-015 With PIPE_HAZARD_PERF_EN defined, stall_cnt SHALL increment (wrapping at 2^32-1 to 0) each cycle pc_stall=1; without it, port stall_cnt and counter SHALL be absent.

Structure
REQ-016 FSM state enum and WAIT_MAX default SHALL be in the shared CPU package.
REQ-017 Load-use comparator SHALL be sub-module hazard_detect (combinational); FSM/counters stay top-level.

Verification
REQ-018 ex_MemRead=1, ex_rd=5, id_rs2=5, no access -> one cycle pc_stall=if_id_stall=id_ex_flush=1, then all 0.
REQ-019 ex_rd=0 load, id_rs1=0 -> no stall.
REQ-020 Load-use plus ex_branch_taken same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-021 me_MemRead=1, dm_ready after 3 cycles -> mem_req 4 cycles, stalls 3 cycles, state RUN after.
REQ-022 me_MemWrite=1, dm_ready never, WAIT_MAX=4 -> mem_err pulse at 4th MEM_WAIT cycle, stalls release, RUN.
REQ-023 rst raised during MEM_WAIT -> mem_req and stalls 0 same cycle; with macro, stall_cnt=0.
